// File: rtl/bc_pkg.sv
// Shared types and fixed control-word programs for the polynomial datapath sequencer.
package bc_pkg;

  typedef struct packed {
    logic       LX;
    logic       LS;
    logic       LH;
    logic       Hula;
    logic [1:0] M0;
    logic [1:0] M1;
    logic [1:0] M2;
  } ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int PROG0_LEN = 19;
  localparam int PROG1_LEN = 8;
  localparam int P0_AW     = $clog2(PROG0_LEN);
  localparam int P1_AW     = $clog2(PROG1_LEN);

  localparam ctrl_t CTRL_IDLE = '0;

  // Bit order per word: LX LS LH Hula M0 M1 M2.
  localparam ctrl_t PROG0 [PROG0_LEN] = '{
    10'b1_0_0_0_00_00_00,
    10'b0_1_0_0_01_00_00,
    10'b0_0_1_1_00_01_00,
    10'b0_1_0_0_10_01_01,
    10'b0_0_1_1_01_10_00,
    10'b0_1_0_0_10_01_01,
    10'b0_0_1_1_01_10_00,
    10'b0_1_0_0_10_01_01,
    10'b0_0_1_1_01_10_00,
    10'b0_1_0_0_10_01_01,
    10'b0_0_1_1_01_10_00,
    10'b0_1_0_0_10_01_01,
    10'b0_0_1_1_01_10_00,
    10'b0_1_0_0_10_01_01,
    10'b0_0_1_1_01_10_00,
    10'b0_1_0_0_10_01_01,
    10'b0_0_1_1_11_10_10,
    10'b0_1_0_1_11_11_01,
    10'b0_0_1_0_00_00_00
  };

  localparam ctrl_t PROG1 [PROG1_LEN] = '{
    10'b1_0_0_0_00_00_00,
    10'b0_1_0_0_01_00_00,
    10'b0_0_1_1_00_01_00,
    10'b0_1_0_0_10_01_01,
    10'b0_0_1_1_01_10_00,
    10'b0_1_0_1_11_11_01,
    10'b0_0_1_0_10_00_10,
    10'b0_1_0_0_00_00_00
  };

  function automatic logic [4:0] last_step(input logic sel);
    return sel ? 5'(PROG1_LEN - 1) : 5'(PROG0_LEN - 1);
  endfunction

  function automatic ctrl_t rom_word(input logic sel, input logic [4:0] idx);
    ctrl_t w;
    w = CTRL_IDLE;
    if (sel) begin
      if (idx < 5'(PROG1_LEN)) w = PROG1[idx[P1_AW-1:0]];
    end else begin
      if (idx < 5'(PROG0_LEN)) w = PROG0[idx[P0_AW-1:0]];
    end
    return w;
  endfunction

endpackage

// File: rtl/bc_sched_if.sv
// Client/datapath-facing bundle of the scheduler: requests in, control lines and status out.
interface bc_sched_if;
  logic [1:0] req;
  logic [1:0] op;
  logic       stop;
  logic       busy;
  logic       gnt_id;
  logic [1:0] done;
  logic       LX;
  logic       LS;
  logic       LH;
  logic       Hula;
  logic [1:0] M0;
  logic [1:0] M1;
  logic [1:0] M2;

  modport master (
    output req, op, stop,
    input  busy, gnt_id, done, LX, LS, LH, Hula, M0, M1, M2
  );

  modport slave (
    input  req, op, stop,
    output busy, gnt_id, done, LX, LS, LH, Hula, M0, M1, M2
  );
endinterface

// File: rtl/bc_rr_arb.sv
// Two-way round-robin arbiter; the pointer remembers the last client granted.
module bc_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       win_id,
  output logic       valid
);

  logic ptr_q, ptr_d;

  always_comb begin
    valid = |req;
    unique case (req)
      2'b01:   win_id = 1'b0;
      2'b10:   win_id = 1'b1;
      2'b11:   win_id = ~ptr_q;
      default: win_id = 1'b0;
    endcase
    ptr_d = (grant_en && valid) ? win_id : ptr_q;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr_q <= 1'b1;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bc_sched.sv
// Grants the datapath to one of two clients and plays the chosen program one word per clock.
module bc_sched
  import bc_pkg::*;
(
  input  logic    clk,
  input  logic    reset,
  bc_sched_if.slave bus
);

  state_e     state_q, state_d;
  logic [4:0] step_q, step_d;
  logic       sel_q, sel_d;
  logic       gnt_q, gnt_d;
  ctrl_t      ctrl_q, ctrl_d;
  logic       busy_q, busy_d;
  logic [1:0] done_q, done_d;

  logic [1:0] arb_req;
  logic       arb_en;
  logic       win_id;
  logic       win_valid;

  // done_q is non-zero only in DONE; masking the finishing client there lets the
  // other client be granted on the edge that ends DONE without re-granting the owner.
  assign arb_req = bus.req & ~done_q;
  assign arb_en  = (state_q != ST_RUN) && !bus.stop;

  bc_rr_arb u_arb (
    .clk      (clk),
    .reset    (reset),
    .req      (arb_req),
    .grant_en (arb_en),
    .win_id   (win_id),
    .valid    (win_valid)
  );

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    ctrl_d  = CTRL_IDLE;
    busy_d  = 1'b0;
    done_d  = 2'b00;

    if (bus.stop) begin
      state_d = ST_IDLE;
      step_d  = '0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          state_d = ST_IDLE;
          if (win_valid) begin
            gnt_d   = win_id;
            sel_d   = bus.op[win_id];
            step_d  = '0;
            ctrl_d  = rom_word(bus.op[win_id], 5'd0);
            busy_d  = 1'b1;
            state_d = ST_RUN;
          end
        end
        ST_RUN: begin
          if (step_q >= last_step(sel_q)) begin
            step_d         = '0;
            done_d[gnt_q]  = 1'b1;
            state_d        = ST_DONE;
          end else begin
            step_d = step_q + 5'd1;
            ctrl_d = rom_word(sel_q, step_q + 5'd1);
            busy_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      sel_q   <= 1'b0;
      gnt_q   <= 1'b0;
      ctrl_q  <= CTRL_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 2'b00;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      ctrl_q  <= ctrl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.gnt_id = gnt_q;
  assign bus.done   = done_q;
  assign bus.LX     = ctrl_q.LX;
  assign bus.LS     = ctrl_q.LS;
  assign bus.LH     = ctrl_q.LH;
  assign bus.Hula   = ctrl_q.Hula;
  assign bus.M0     = ctrl_q.M0;
  assign bus.M1     = ctrl_q.M1;
  assign bus.M2     = ctrl_q.M2;

endmodule

// File: tb/tb_bc_sched.sv
// Scoreboard bench for bc_sched: expected per-cycle outputs are queued at stimulus time.
module tb_bc_sched;
  import bc_pkg::*;

  typedef struct {
    ctrl_t      ctrl;
    logic       busy;
    logic [1:0] done;
    logic       gnt;
    logic [1:0] drop;
  } exp_t;

  localparam logic [9:0] W0 = 10'b1_0_0_0_00_00_00;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  bc_sched_if bus ();

  bc_sched u_dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [13:0] sample();
    return {bus.LX, bus.LS, bus.LH, bus.Hula, bus.M0, bus.M1, bus.M2,
            bus.busy, bus.done, bus.gnt_id};
  endfunction

  function automatic void push_prog(input logic id, input logic sel, input logic [1:0] drop);
    int         len;
    logic [4:0] ix;
    exp_t       e;
    len = sel ? PROG1_LEN : PROG0_LEN;
    for (int i = 0; i < len; i++) begin
      ix = 5'(i);
      if (i == 0)   e.ctrl = ctrl_t'(W0);
      else if (sel) e.ctrl = PROG1[ix[P1_AW-1:0]];
      else          e.ctrl = PROG0[ix[P0_AW-1:0]];
      e.busy = 1'b1;
      e.done = 2'b00;
      e.gnt  = id;
      e.drop = 2'b00;
      sb.push_back(e);
    end
    e.ctrl = CTRL_IDLE;
    e.busy = 1'b0;
    e.done = id ? 2'b10 : 2'b01;
    e.gnt  = id;
    e.drop = drop;
    sb.push_back(e);
  endfunction

  // Pops one expectation per cycle; each pop is compared at the falling edge.
  task automatic drain(input string name, input int max_n);
    int          n;
    exp_t        e;
    logic [13:0] act;
    logic [13:0] exp_v;
    n = 0;
    while (sb.size() > 0 && n < max_n) begin
      @(negedge clk);
      e     = sb.pop_front();
      act   = sample();
      exp_v = {e.ctrl, e.busy, e.done, e.gnt};
      checks++;
      if (act !== exp_v) begin
        errors++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, n, act, exp_v);
      end
      bus.req = bus.req & ~e.drop;
      n++;
    end
  endtask

  task automatic check_idle(input string name, input logic gnt, input int n);
    logic [13:0] act;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      act = sample();
      checks++;
      if (act !== {13'b0, gnt}) begin
        errors++;
        $display("FAIL %s idle %0d: got %h expected %h", name, i, act, {13'b0, gnt});
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    bus.req  = 2'b00;
    bus.op   = 2'b00;
    bus.stop = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [13:0] act;
    rst_n    = 1'b0;
    bus.req  = 2'b00;
    bus.op   = 2'b00;
    bus.stop = 1'b0;
    #3;
    act = sample();
    checks++;
    if (act !== 14'b0) begin
      errors++;
      $display("FAIL reset_values: got %h expected %h", act, 14'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    check_idle("after_reset", 1'b0, 2);
  endtask

  task automatic test_single_p0();
    do_reset();
    bus.op  = 2'b00;
    bus.req = 2'b01;
    push_prog(1'b0, 1'b0, 2'b01);
    drain("single_p0", 100);
    check_idle("single_p0_end", 1'b0, 2);
  endtask

  task automatic test_prog1();
    do_reset();
    bus.op  = 2'b10;
    bus.req = 2'b10;
    push_prog(1'b1, 1'b1, 2'b10);
    drain("prog1", 100);
    check_idle("prog1_end", 1'b1, 2);
  endtask

  task automatic test_tie();
    do_reset();
    bus.op  = 2'b00;
    bus.req = 2'b11;
    push_prog(1'b0, 1'b0, 2'b01);
    push_prog(1'b1, 1'b0, 2'b10);
    drain("tie", 200);
    check_idle("tie_end", 1'b1, 2);
  endtask

  task automatic test_stop();
    do_reset();
    bus.op  = 2'b00;
    bus.req = 2'b01;
    push_prog(1'b0, 1'b0, 2'b01);
    drain("stop_pre", 6);
    bus.stop = 1'b1;
    bus.req  = 2'b00;
    sb.delete();
    check_idle("stop_abort", 1'b0, 1);
    bus.stop = 1'b0;
    check_idle("stop_no_done", 1'b0, 3);
    // stop and a new request on the same edge: stop must win
    bus.stop = 1'b1;
    bus.req  = 2'b01;
    check_idle("stop_vs_req", 1'b0, 1);
    bus.stop = 1'b0;
    push_prog(1'b0, 1'b0, 2'b01);
    drain("stop_regrant", 100);
    check_idle("stop_end", 1'b0, 1);
  endtask

  task automatic test_async_reset();
    logic [13:0] act;
    do_reset();
    bus.op  = 2'b00;
    bus.req = 2'b01;
    push_prog(1'b0, 1'b0, 2'b01);
    drain("mid_reset_pre", 8);
    #2;
    rst_n = 1'b0;
    #1;
    act = sample();
    checks++;
    if (act !== 14'b0) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", act, 14'b0);
    end
    sb.delete();
    bus.req = 2'b00;
    check_idle("reset_hold", 1'b0, 1);
    rst_n = 1'b1;
    check_idle("reset_release", 1'b0, 2);
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.op  = 2'b10;
    bus.req = 2'b11;
    push_prog(1'b0, 1'b0, 2'b00);
    push_prog(1'b1, 1'b1, 2'b00);
    push_prog(1'b0, 1'b0, 2'b00);
    push_prog(1'b1, 1'b1, 2'b11);
    drain("back_to_back", 500);
    check_idle("back_to_back_end", 1'b1, 2);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    bus.req  = 2'b00;
    bus.op   = 2'b00;
    bus.stop = 1'b0;
    test_reset();
    test_single_p0();
    test_prog1();
    test_tie();
    test_stop();
    test_async_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
